// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock,
// rippling the carry through a flop. Define ADDSUB_OVF_EN to add the signed-overflow port.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_addsub: WIDTH must be an exact multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;
  logic             last_chunk;

  // One CHUNK-wide slice of the datapath, selected by the chunk counter.
  always_comb begin
    a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
    last_chunk = (cnt_q == CW'(N - 1));
`ifdef ADDSUB_OVF_EN
    msb_cin = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the inverted operand and seed of 1 are latched here.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
          sum_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
`ifdef ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*CHUNK +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          cout_d  = c_chunk;
`ifdef ADDSUB_OVF_EN
          ovf_d   = msb_cin ^ c_chunk;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADDSUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub: a CHUNK=4 instance for the vector table and corner
// sequences, and a CHUNK=16 instance for single-cycle latency. Honours ADDSUB_OVF_EN.
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid16;
  logic        out_ready, out_ready16;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        in_ready, out_valid, cout;
  logic [15:0] sum;
  logic        in_ready16, out_valid16, cout16;
  logic [15:0] sum16;
`ifdef ADDSUB_OVF_EN
  logic        ovf, ovf16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
`ifdef ADDSUB_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
`ifdef ADDSUB_OVF_EN
    .ovf(ovf16),
`endif
    .cout(cout16)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Accept one operation, scramble the inputs during RUN and measure latency to out_valid.
  task automatic applyStimulus(input bit wide, input logic [15:0] va, input logic [15:0] vb,
                               input logic vcin, input logic vsub, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub;
    if (wide) in_valid16 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid16 = 1'b0;
    a = ~va; b = ~vb; cin = ~vcin; sub = ~vsub;
    lat = 0;
    while (!(wide ? out_valid16 : out_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " latency"}, lat, exp_lat);
  endtask

  task automatic releaseResult(input bit wide, input string name);
    @(negedge clk);
    if (wide) out_ready16 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready16 = 1'b0;
    checkOutput({name, " in_ready after release"}, wide ? in_ready16 : in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_valid16 = 1'b0;
    out_ready = 1'b0; out_ready16 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    checkOutput("reset in_ready16", in_ready16, 1);
`ifdef ADDSUB_OVF_EN
    checkOutput("reset ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 4, $sformatf("v%0d", i));
      checkOutput($sformatf("v%0d sum", i), sum, vecs[i].exp_sum);
      checkOutput($sformatf("v%0d cout", i), cout, vecs[i].exp_cout);
`ifdef ADDSUB_OVF_EN
      checkOutput($sformatf("v%0d ovf", i), ovf, vecs[i].exp_ovf);
`endif
      releaseResult(1'b0, $sformatf("v%0d", i));
    end

    // Backpressure: result must hold in DONE while in_valid and a wiggle.
    applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, "bp");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = a + 16'h1111;
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d out_valid", k), out_valid, 1);
      checkOutput($sformatf("bp%0d in_ready", k), in_ready, 0);
      checkOutput($sformatf("bp%0d sum", k), sum, 16'h5555);
      checkOutput($sformatf("bp%0d cout", k), cout, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'hAAAA; b = 16'h0000; sub = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checkOutput("bp release in_ready", in_ready, 1);
    checkOutput("bp release out_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("bp no turnaround accept", in_ready, 1);

    // Asynchronous reset after E2 aborts the operation without a clock edge.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    checkOutput("pre-abort partial sum", sum, 16'h0055);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort sum", sum, 0);
    checkOutput("abort cout", cout, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort held out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 4, "post-abort");
    checkOutput("post-abort sum", sum, 16'h0002);
    checkOutput("post-abort cout", cout, 0);
    releaseResult(1'b0, "post-abort");

    // Single-chunk instance: one RUN cycle.
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, "w16a");
    checkOutput("w16a sum", sum16, 16'h8000);
    checkOutput("w16a cout", cout16, 0);
`ifdef ADDSUB_OVF_EN
    checkOutput("w16a ovf", ovf16, 1);
`endif
    releaseResult(1'b1, "w16a");
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1, "w16b");
    checkOutput("w16b sum", sum16, 16'hFFFE);
    checkOutput("w16b cout", cout16, 0);
    releaseResult(1'b1, "w16b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
